// File: rtl/custom_counter_pkg.sv
// Shared constants and parameter checking for the custom_counter family.
package custom_counter_pkg;

  localparam bit SAT_MODE_WRAP = 1'b0;
  localparam bit SAT_MODE_HOLD = 1'b1;

  // A width must hold at least one bit, and the top count must fit in that width.
  function automatic bit counterParamsOk(input int width, input longint unsigned modMax);
    if (width < 1) return 1'b0;
    if (width >= 64) return 1'b1;
    return modMax < (64'd1 << width);
  endfunction

endpackage

// File: rtl/custom_counter_if.sv
// Control and status bundle of one counter stage; the master drives controls, the counter is the slave.
interface custom_counter_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             UP;
  logic             CLR;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] COUNT;
  logic             TC;
  logic             WRAP;
  logic             SAT;

  modport master (output EN, UP, CLR, LOAD, LOAD_VAL, input COUNT, TC, WRAP, SAT);
  modport slave  (input EN, UP, CLR, LOAD, LOAD_VAL, output COUNT, TC, WRAP, SAT);
endinterface

// File: rtl/custom_counter_next.sv
// Next-state logic of the counter: CLR > LOAD > EN > hold, plus the combinational terminal count.
module custom_counter_next
  import custom_counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MOD_MAX  = (2**WIDTH) - 1,
  parameter bit          SATURATE = SAT_MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             satCur,
  output logic [WIDTH-1:0] countNext,
  output logic             wrapNext,
  output logic             satNext,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD_MAX);

  logic atMax;
  logic atZero;
  logic atBound;

  // The bound is tested before stepping, so the add never needs a carry bit.
  assign atMax   = (count == MaxVal);
  assign atZero  = (count == '0);
  assign atBound = up ? atMax : atZero;
  assign tc      = en & atBound;

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred on any path.
    countNext = count;
    wrapNext  = 1'b0;
    satNext   = satCur;
    if (clr) begin
      countNext = '0;
      satNext   = 1'b0;
    end else if (load) begin
      countNext = (loadVal > MaxVal) ? MaxVal : loadVal;
      satNext   = 1'b0;
    end else if (en) begin
      satNext = 1'b0;
      if (!atBound) begin
        countNext = up ? count + 1'b1 : count - 1'b1;
      end else if (SATURATE == SAT_MODE_HOLD) begin
        satNext = 1'b1;
      end else begin
        countNext = up ? '0 : MaxVal;
        wrapNext  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/custom_counter_param.sv
// Parametrised up/down counter with load, clear, wrap/saturate and cascade outputs; all flops on CLK.
module custom_counter_param
  import custom_counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MOD_MAX  = (2**WIDTH) - 1,
  parameter bit          SATURATE = SAT_MODE_WRAP
) (
  input  logic            CLK,
  input  logic            RST,
  custom_counter_if.slave bus
);

  generate
    if (!counterParamsOk(WIDTH, MOD_MAX)) begin : gBadParams
      $error("custom_counter_param: need WIDTH >= 1 and MOD_MAX < 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] countQ;
  logic [WIDTH-1:0] countD;
  logic             wrapQ;
  logic             wrapD;
  logic             satQ;
  logic             satD;
  logic             tc;

  custom_counter_next #(
    .WIDTH   (WIDTH),
    .MOD_MAX (MOD_MAX),
    .SATURATE(SATURATE)
  ) uNext (
    .count    (countQ),
    .up       (bus.UP),
    .en       (bus.EN),
    .clr      (bus.CLR),
    .load     (bus.LOAD),
    .loadVal  (bus.LOAD_VAL),
    .satCur   (satQ),
    .countNext(countD),
    .wrapNext (wrapD),
    .satNext  (satD),
    .tc       (tc)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      countQ <= '0;
      wrapQ  <= 1'b0;
      satQ   <= 1'b0;
    end else begin
      // NOTE: non-blocking so COUNT, WRAP and SAT all update from the same pre-edge values.
      countQ <= countD;
      wrapQ  <= wrapD;
      satQ   <= satD;
    end
  end

  assign bus.COUNT = countQ;
  assign bus.WRAP  = wrapQ;
  assign bus.SAT   = satQ;
  assign bus.TC    = tc;

endmodule
